vit_3by4_dec_rp_sched: RTL and testbench

Frame scheduler in front of the 3/4 Viterbi recursive processor. Accepts the branch-metric stream from the BM unit under a ready/valid handshake and enforces a programmed frame length. Allocates one of pBANK_NUM traceback-buffer banks per frame and emits a 1-cycle registered, cleaned sop/val/eop/tag/metric stream to the recursive processor. A frame does not start until a bank is free; banks are returned by the traceback unit.

---
 rtl/vit_3by4_dec_sched_pkg.sv | 18 +
 rtl/vit_3by4_dec_bank_alloc.sv | 45 ++++
 rtl/vit_3by4_dec_rp_sched.sv | 120 ++++++++++++
 tb/tb_vit_3by4_dec_rp_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_3by4_dec_sched_pkg.sv
// Shared types for the 3/4 Viterbi frame scheduler: FSM states and tag/bank types.
// Widths here match the default scheduler configuration.
package vit_3by4_dec_sched_pkg;

    localparam int cTAG_W    = 4;
    localparam int cBANK_NUM = 2;
    localparam int cBANK_W   = $clog2(cBANK_NUM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic [cTAG_W-1:0]  tag_t;
    typedef logic [cBANK_W-1:0] bank_t;

endpackage

// File: rtl/vit_3by4_dec_bank_alloc.sv
// Traceback bank free mask with lowest-index-free priority encoder.
// Latency: allocation and release take effect on the next clock edge.
// Backpressure: none; any_free tells the scheduler whether a frame may start.
module vit_3by4_dec_bank_alloc #(
    parameter  int pBANK_NUM = 2,
    localparam int cBANK_W   = $clog2(pBANK_NUM)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 alloc,
    input  logic [pBANK_NUM-1:0] rel,
    output logic                 any_free,
    output logic [cBANK_W-1:0]   low_free
);

    logic [pBANK_NUM-1:0] fm;
    logic [pBANK_NUM-1:0] alloc_oh;

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        low_free = '0;
        for (int i = pBANK_NUM - 1; i >= 0; i--) begin
            if (fm[i]) low_free = cBANK_W'(i);
        end
    end

    always_comb begin
        alloc_oh = '0;
        if (alloc) alloc_oh[low_free] = 1'b1;
    end

    assign any_free = |fm;

    // Allocation chooses from the current mask, so a same-cycle release of that
    // bank (already free) cannot resurrect it.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            fm <= '1;
        end else if (iclkena) begin
            fm <= (fm | rel) & ~alloc_oh;
        end
    end

endmodule

// File: rtl/vit_3by4_dec_rp_sched.sv
// Frame scheduler in front of the 3/4 Viterbi recursive processor.
// Latency: 1 cycle idat->odat, framing/tag/bank aligned with odat.
// Backpressure: oready low in IDLE while no traceback bank is free, or when iclkena is low.
module vit_3by4_dec_rp_sched
    import vit_3by4_dec_sched_pkg::*;
#(
    parameter  int pTAG_W    = 4,
    parameter  int pDAT_W    = 32,
    parameter  int pLEN_W    = 12,
    parameter  int pBANK_NUM = 2,
    localparam int cBANK_W   = $clog2(pBANK_NUM)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic [pLEN_W-1:0]    ilen,
    input  logic                 isop,
    input  logic                 ival,
    input  logic                 ieop,
    input  logic [pTAG_W-1:0]    itag,
    input  logic [pDAT_W-1:0]    idat,
    input  logic [pBANK_NUM-1:0] ibank_free,
    output logic                 oready,
    output logic                 osop,
    output logic                 oval,
    output logic                 oeop,
    output logic [pTAG_W-1:0]    otag,
    output logic [cBANK_W-1:0]   obank,
    output logic [pDAT_W-1:0]    odat,
    output logic                 oerr,
    output logic                 obusy
);

    state_t              state;
    logic [pLEN_W-1:0]   cnt;
    logic [pLEN_W-1:0]   len_last;
    logic                any_free;
    logic [cBANK_W-1:0]  low_free;
    logic                xfer;
    logic                alloc;
    logic                is_last;

    assign oready  = ireset & iclkena & ((state != ST_IDLE) | any_free);
    assign xfer    = ival & oready;
    assign alloc   = xfer & isop & (state == ST_IDLE);
    assign is_last = (cnt == len_last);
    assign obusy   = (state != ST_IDLE);

    vit_3by4_dec_bank_alloc #(.pBANK_NUM(pBANK_NUM)) u_bank_alloc (
        .iclk     (iclk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .alloc    (alloc),
        .rel      (ibank_free),
        .any_free (any_free),
        .low_free (low_free)
    );

    // cnt holds the index of the next symbol within the frame; the sop symbol is index 0.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len_last <= '0;
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            oerr     <= 1'b0;
            otag     <= '0;
            obank    <= '0;
            odat     <= '0;
        end else if (iclkena) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            oerr <= 1'b0;
            if (xfer) begin
                unique case (state)
                    ST_IDLE: begin
                        if (isop) begin
                            oval     <= 1'b1;
                            osop     <= 1'b1;
                            oeop     <= ieop;
                            oerr     <= ieop;
                            otag     <= itag;
                            obank    <= low_free;
                            odat     <= idat;
                            len_last <= (ilen < pLEN_W'(2)) ? pLEN_W'(1) : ilen - pLEN_W'(1);
                            cnt      <= pLEN_W'(1);
                            state    <= ieop ? ST_IDLE : ST_RUN;
                        end else begin
                            oerr <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        oval <= 1'b1;
                        odat <= idat;
                        if (ieop) begin
                            oeop  <= 1'b1;
                            oerr  <= isop | ~is_last;
                            state <= ST_IDLE;
                        end else if (is_last) begin
                            oeop  <= 1'b1;
                            oerr  <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            oerr <= isop;
                            cnt  <= cnt + pLEN_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (ieop) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vit_3by4_dec_rp_sched.sv
// Randomized scoreboard bench for vit_3by4_dec_rp_sched against a frame-level reference model.
module tb_vit_3by4_dec_rp_sched;

    localparam int NB = 2;

    logic          iclk = 1'b0;
    logic          ireset = 1'b0;
    logic          iclkena = 1'b1;
    logic [11:0]   ilen = '0;
    logic          isop = 1'b0;
    logic          ival = 1'b0;
    logic          ieop = 1'b0;
    logic [3:0]    itag = '0;
    logic [31:0]   idat = '0;
    logic [NB-1:0] ibank_free = '0;
    logic          oready, osop, oval, oeop, oerr, obusy;
    logic [3:0]    otag;
    logic [0:0]    obank;
    logic [31:0]   odat;

    vit_3by4_dec_rp_sched dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ilen(ilen),
        .isop(isop), .ival(ival), .ieop(ieop), .itag(itag), .idat(idat),
        .ibank_free(ibank_free), .oready(oready), .osop(osop), .oval(oval),
        .oeop(oeop), .otag(otag), .obank(obank), .odat(odat), .oerr(oerr),
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        bit          val;
        bit          sop;
        bit          eop;
        bit          err;
        logic [3:0]  tag;
        int          bank;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: frame mode (0 idle, 1 in frame, 2 discarding), symbol index, free banks.
    int          mst = 0;
    int          idx = 0;
    int          flen = 2;
    logic [3:0]  ftag = '0;
    int          fbank = 0;
    bit [NB-1:0] fre = '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge iclk or negedge ireset) begin : model
        exp_t        e;
        bit [NB-1:0] old;
        bit          rdy;
        int          b;
        bit          do_alloc;
        if (!ireset) begin
            mst = 0;
            idx = 0;
            fre = '1;
            q.delete();
        end else if (iclkena) begin
            old = fre;
            rdy = (mst != 0) || (old != 0);
            do_alloc = 1'b0;
            b = 0;
            e.val = 0; e.sop = 0; e.eop = 0; e.err = 0;
            e.tag = ftag; e.bank = fbank; e.dat = idat;
            if (ival && rdy) begin
                if (mst == 0) begin
                    if (isop) begin
                        for (int i = NB - 1; i >= 0; i--) if (old[i]) b = i;
                        do_alloc = 1'b1;
                        flen  = (ilen < 2) ? 2 : int'(ilen);
                        ftag  = itag;
                        fbank = b;
                        idx   = 1;
                        e.val = 1; e.sop = 1; e.eop = ieop; e.err = ieop;
                        e.tag = ftag; e.bank = fbank;
                        mst   = ieop ? 0 : 1;
                    end else begin
                        e.err = 1;
                    end
                    q.push_back(e);
                end else if (mst == 1) begin
                    e.val = 1;
                    if (ieop) begin
                        e.eop = 1;
                        e.err = isop || (idx != flen - 1);
                        mst = 0;
                    end else if (idx == flen - 1) begin
                        e.eop = 1;
                        e.err = 1;
                        mst = 2;
                    end else begin
                        e.err = isop;
                        idx++;
                    end
                    q.push_back(e);
                end else begin
                    if (ieop) mst = 0;
                end
            end
            fre = old | ibank_free;
            if (do_alloc) fre[b] = 1'b0;
        end
    end

    always @(negedge iclk) begin : monitor
        exp_t e;
        if (!ireset) begin
            chk("reset_outputs", {oready, oval, osop, oeop, oerr, obusy, otag, 1'(obank)},
                32'd0);
            chk("reset_odat", odat, 32'd0);
        end else begin
            chk("oready", 32'(oready), 32'(iclkena && ((mst != 0) || (fre != 0))));
            chk("obusy", 32'(obusy), 32'(mst != 0));
            if (q.size() > 0) e = q.pop_front();
            else begin
                e.val = 0; e.sop = 0; e.eop = 0; e.err = 0;
                e.tag = '0; e.bank = 0; e.dat = '0;
            end
            chk("oval", 32'(oval), 32'(e.val));
            chk("oerr", 32'(oerr), 32'(e.err));
            if (e.val) begin
                chk("osop", 32'(osop), 32'(e.sop));
                chk("oeop", 32'(oeop), 32'(e.eop));
                chk("otag", 32'(otag), 32'(e.tag));
                chk("obank", 32'(obank), e.bank);
                chk("odat", odat, e.dat);
            end
        end
    end

    int gap_max = 0;

    task automatic idle(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic send(input bit s, input bit e, input logic [3:0] t, input logic [11:0] l);
        ival = 1'b1; isop = s; ieop = e; itag = t; ilen = l; idat = $urandom;
        for (int w = 0; ; w++) begin
            @(negedge iclk);
            if (oready) break;
            if (w > 2000) begin
                checks++; errors++;
                $display("FAIL send_timeout: oready stayed 0 for %0d cycles", w);
                break;
            end
        end
        @(posedge iclk);
        #1;
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        itag = 4'($urandom); ilen = 12'($urandom); idat = $urandom;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle(1);
    endtask

    // Non-sop symbols carry junk tag/len so that only the sop values may be captured.
    task automatic frame(input logic [3:0] t, input int l, input int neop, input int mid);
        for (int k = 0; k < neop; k++)
            send(k == 0 || k == mid, k == neop - 1, (k == 0) ? t : 4'($urandom),
                 (k == 0) ? 12'(l) : 12'($urandom));
    endtask

    task automatic rel(input logic [NB-1:0] m);
        ibank_free = m;
        idle(1);
        ibank_free = '0;
    endtask

    bit stop_rel = 0;

    initial begin
        idle(3);
        ireset = 1'b1;
        idle(1);
        // Nominal 8-symbol frame
        frame(4'h5, 8, 8, -1);
        idle(2);
        rel(2'b11);
        // Three back-to-back frames; the third waits for a bank release
        frame(4'h1, 8, 8, -1);
        frame(4'h2, 8, 8, -1);
        fork
            frame(4'h3, 8, 8, -1);
            begin idle(10); rel(2'b01); end
        join
        idle(2);
        rel(2'b11);
        // Short, then long frame, then junk and mid-frame sop
        frame(4'h7, 8, 5, -1);
        rel(2'b11);
        frame(4'h8, 8, 12, -1);
        rel(2'b11);
        send(1'b0, 1'b0, 4'h0, 12'd4);
        send(1'b0, 1'b1, 4'h0, 12'd4);
        frame(4'h9, 6, 6, 3);
        frame(4'hA, 0, 2, -1);
        rel(2'b11);
        frame(4'hB, 5, 1, -1);
        idle(2);
        rel(2'b11);
        // Clock enable low: no acceptance
        idle(2);
        iclkena = 1'b0;
        ival = 1'b1; isop = 1'b1;
        idle(3);
        ival = 1'b0; isop = 1'b0;
        iclkena = 1'b1;
        idle(2);
        // Reset mid-frame on bank 1; next frame must restart on bank 0
        frame(4'hC, 4, 4, -1);
        send(1'b1, 1'b0, 4'hD, 12'd8);
        send(1'b0, 1'b0, 4'h0, 12'd0);
        send(1'b0, 1'b0, 4'h0, 12'd0);
        ireset = 1'b0;
        idle(2);
        #1 ireset = 1'b1;
        idle(1);
        frame(4'hE, 4, 4, -1);
        idle(2);
        // Randomized frames with concurrent random bank releases
        gap_max = 2;
        fork
            begin
                while (!stop_rel) begin
                    @(posedge iclk);
                    #1;
                    ibank_free = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
                end
                ibank_free = '0;
            end
            begin
                for (int f = 0; f < 40; f++) begin
                    int l, el, ne, md;
                    l  = $urandom_range(0, 12);
                    el = (l < 2) ? 2 : l;
                    ne = $urandom_range(1, el + 3);
                    md = ($urandom_range(0, 4) == 0) ? $urandom_range(1, ne) : -1;
                    if ($urandom_range(0, 4) == 0) send(1'b0, 1'($urandom), 4'h0, 12'd3);
                    frame(4'($urandom), l, ne, md);
                end
                stop_rel = 1;
            end
        join
        idle(5);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
